// File: rtl/gcd_operand_sequencer_if.sv
// Bundle of the upstream operand handshake, the GCD controller bus and the
// downstream result handshake for gcd_operand_sequencer.
interface gcd_operand_sequencer_if #(
   parameter int WIDTH = 16
);
   logic             op_valid;
   logic             op_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             gcd_start;
   logic [WIDTH-1:0] gcd_data;
   logic             gcd_done;
   logic [WIDTH-1:0] gcd_result;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic             res_err;
   logic             busy;

   modport master (
      input  op_valid, op_a, op_b, gcd_done, gcd_result, res_ready,
      output op_ready, gcd_start, gcd_data, res_valid, res_data, res_err, busy
   );

   modport slave (
      output op_valid, op_a, op_b, gcd_done, gcd_result, res_ready,
      input  op_ready, gcd_start, gcd_data, res_valid, res_data, res_err, busy
   );
endinterface

// File: rtl/gcd_operand_sequencer.sv
// Feeds an operand pair to the subtractive GCD controller (A then B on the
// shared data bus), waits for done or timeout and hands the result downstream.
module gcd_operand_sequencer #(
   parameter int WIDTH    = 16,
   parameter int LOAD_CYC = 1,
   parameter int TIMEOUT  = 65535
) (
   input logic clk,
   input logic rst,
   gcd_operand_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_A,
      ST_LOAD_B,
      ST_WAIT,
      ST_RESP
   } state_t;

   localparam logic [3:0]  LOAD_LAST = 4'(LOAD_CYC - 1);
   localparam logic [16:0] TIMEOUT_L = 17'(TIMEOUT);

   state_t           state_q, state_n;
   logic             start_q, start_n;
   logic [WIDTH-1:0] data_q, data_n;
   logic [WIDTH-1:0] b_q, b_n;
   logic             rvalid_q, rvalid_n;
   logic [WIDTH-1:0] rdata_q, rdata_n;
   logic             rerr_q, rerr_n;
   logic             busy_q, busy_n;
   logic [3:0]       lcnt_q, lcnt_n;
   logic [15:0]      tcnt_q, tcnt_n;
   logic [16:0]      tcnt_inc;

   assign tcnt_inc = {1'b0, tcnt_q} + 17'd1;

   // Every output except op_ready is a flop so the GCD bus and result port
   // are glitch-free; op_ready has to react combinationally to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         start_q  <= 1'b0;
         data_q   <= '0;
         b_q      <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rerr_q   <= 1'b0;
         busy_q   <= 1'b0;
         lcnt_q   <= '0;
         tcnt_q   <= '0;
      end else begin
         state_q  <= state_n;
         start_q  <= start_n;
         data_q   <= data_n;
         b_q      <= b_n;
         rvalid_q <= rvalid_n;
         rdata_q  <= rdata_n;
         rerr_q   <= rerr_n;
         busy_q   <= busy_n;
         lcnt_q   <= lcnt_n;
         tcnt_q   <= tcnt_n;
      end
   end

   // Next-state logic computes the value each output register takes on
   // entering the next state, so outputs line up with the state they belong to.
   always_comb begin
      state_n  = state_q;
      start_n  = start_q;
      data_n   = data_q;
      b_n      = b_q;
      rvalid_n = rvalid_q;
      rdata_n  = rdata_q;
      rerr_n   = rerr_q;
      lcnt_n   = lcnt_q;
      tcnt_n   = tcnt_q;

      case (state_q)
         ST_IDLE: begin
            start_n  = 1'b0;
            data_n   = '0;
            rvalid_n = 1'b0;
            if (bus.op_valid) begin
               b_n = bus.op_b;
               if (bus.op_a == '0 && bus.op_b == '0) begin
                  state_n  = ST_RESP;
                  rvalid_n = 1'b1;
                  rdata_n  = '0;
                  rerr_n   = 1'b1;
               end else if (bus.op_a == '0 || bus.op_b == '0) begin
                  state_n  = ST_RESP;
                  rvalid_n = 1'b1;
                  rdata_n  = bus.op_a | bus.op_b;
                  rerr_n   = 1'b0;
               end else begin
                  state_n = ST_LOAD_A;
                  start_n = 1'b1;
                  data_n  = bus.op_a;
                  lcnt_n  = '0;
               end
            end
         end

         ST_LOAD_A: begin
            if (lcnt_q == LOAD_LAST) begin
               state_n = ST_LOAD_B;
               data_n  = b_q;
               lcnt_n  = '0;
            end else begin
               lcnt_n = lcnt_q + 4'd1;
            end
         end

         ST_LOAD_B: begin
            if (lcnt_q == LOAD_LAST) begin
               state_n = ST_WAIT;
               tcnt_n  = '0;
            end else begin
               lcnt_n = lcnt_q + 4'd1;
            end
         end

         ST_WAIT: begin
            // done is checked first so it wins over a coincident timeout
            if (bus.gcd_done) begin
               state_n  = ST_RESP;
               start_n  = 1'b0;
               data_n   = '0;
               rvalid_n = 1'b1;
               rdata_n  = bus.gcd_result;
               rerr_n   = 1'b0;
            end else if (tcnt_inc >= TIMEOUT_L) begin
               state_n  = ST_RESP;
               start_n  = 1'b0;
               data_n   = '0;
               rvalid_n = 1'b1;
               rdata_n  = '0;
               rerr_n   = 1'b1;
            end else if (tcnt_q != 16'hFFFF) begin
               tcnt_n = tcnt_q + 16'd1;
            end
         end

         ST_RESP: begin
            if (bus.res_ready) begin
               state_n  = ST_IDLE;
               rvalid_n = 1'b0;
            end
         end

         default: begin
            state_n  = ST_IDLE;
            start_n  = 1'b0;
            data_n   = '0;
            rvalid_n = 1'b0;
         end
      endcase

      busy_n = (state_n != ST_IDLE);
   end

   assign bus.op_ready  = (state_q == ST_IDLE);
   assign bus.gcd_start = start_q;
   assign bus.gcd_data  = data_q;
   assign bus.res_valid = rvalid_q;
   assign bus.res_data  = rdata_q;
   assign bus.res_err   = rerr_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// Directed bench for gcd_operand_sequencer: a vector table on a LOAD_CYC=1
// instance plus hand-written backpressure, reset and LOAD_CYC=3 sequences.
module tb_gcd_operand_sequencer;

   localparam int W    = 16;
   localparam int TO   = 50;
   localparam int LC1  = 1;
   localparam int LC3  = 3;

   logic clk;
   logic rst;

   gcd_operand_sequencer_if #(.WIDTH(W)) if1 ();
   gcd_operand_sequencer_if #(.WIDTH(W)) if3 ();

   gcd_operand_sequencer #(.WIDTH(W), .LOAD_CYC(LC1), .TIMEOUT(TO)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1.master)
   );

   gcd_operand_sequencer #(.WIDTH(W), .LOAD_CYC(LC3), .TIMEOUT(TO)) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (if3.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           doneCycle;
      logic [W-1:0] modelResult;
      logic [W-1:0] expData;
      logic         expErr;
   } vec_t;

   vec_t vecs[8];
   int   numApplied = 0;
   int   numMiscompares = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      numApplied++;
      if (actual !== expected) begin
         numMiscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one pair to dut1, play the GCD controller and stop in RESP
   task automatic applyStimulus(input vec_t v);
      bit zeroPath;
      int waitCycles;
      zeroPath     = (v.a == '0) || (v.b == '0);
      if1.op_a     = v.a;
      if1.op_b     = v.b;
      if1.op_valid = 1'b1;
      checkOutput("op_ready_idle", 32'(if1.op_ready), 32'd1);
      step();
      if1.op_valid = 1'b0;
      if (!zeroPath) begin
         for (int i = 0; i < LC1; i++) begin
            checkOutput("load_a_start", 32'(if1.gcd_start), 32'd1);
            checkOutput("load_a_data", 32'(if1.gcd_data), 32'(v.a));
            step();
         end
         for (int i = 0; i < LC1; i++) begin
            checkOutput("load_b_start", 32'(if1.gcd_start), 32'd1);
            checkOutput("load_b_data", 32'(if1.gcd_data), 32'(v.b));
            step();
         end
         waitCycles = (v.doneCycle > 0 && v.doneCycle <= TO) ? v.doneCycle : TO;
         for (int w = 1; w <= waitCycles; w++) begin
            checkOutput("wait_res_valid", 32'(if1.res_valid), 32'd0);
            checkOutput("wait_start", 32'(if1.gcd_start), 32'd1);
            checkOutput("wait_data", 32'(if1.gcd_data), 32'(v.b));
            if (w == v.doneCycle) begin
               if1.gcd_done   = 1'b1;
               if1.gcd_result = v.modelResult;
            end
            step();
            if1.gcd_done   = 1'b0;
            if1.gcd_result = '0;
         end
      end
      checkOutput("resp_valid", 32'(if1.res_valid), 32'd1);
      checkOutput("resp_data", 32'(if1.res_data), 32'(v.expData));
      checkOutput("resp_err", 32'(if1.res_err), 32'(v.expErr));
      checkOutput("resp_start", 32'(if1.gcd_start), 32'd0);
      checkOutput("resp_gcd_data", 32'(if1.gcd_data), 32'd0);
      checkOutput("resp_op_ready", 32'(if1.op_ready), 32'd0);
      checkOutput("resp_busy", 32'(if1.busy), 32'd1);
   endtask

   task automatic completeResp();
      if1.res_ready = 1'b1;
      step();
      if1.res_ready = 1'b0;
      checkOutput("idle_res_valid", 32'(if1.res_valid), 32'd0);
      checkOutput("idle_op_ready", 32'(if1.op_ready), 32'd1);
      checkOutput("idle_busy", 32'(if1.busy), 32'd0);
   endtask

   initial begin
      vec_t v;
      vecs[0] = '{a: 16'd143, b: 16'd78, doneCycle: 20, modelResult: 16'd13, expData: 16'd13, expErr: 1'b0};
      vecs[1] = '{a: 16'd0,   b: 16'd0,  doneCycle: 0,  modelResult: 16'd0,  expData: 16'd0,  expErr: 1'b1};
      vecs[2] = '{a: 16'd0,   b: 16'd25, doneCycle: 0,  modelResult: 16'd0,  expData: 16'd25, expErr: 1'b0};
      vecs[3] = '{a: 16'd40,  b: 16'd0,  doneCycle: 0,  modelResult: 16'd0,  expData: 16'd40, expErr: 1'b0};
      vecs[4] = '{a: 16'd12,  b: 16'd18, doneCycle: 5,  modelResult: 16'd6,  expData: 16'd6,  expErr: 1'b0};
      vecs[5] = '{a: 16'd9,   b: 16'd6,  doneCycle: 0,  modelResult: 16'd0,  expData: 16'd0,  expErr: 1'b1};
      vecs[6] = '{a: 16'd27,  b: 16'd15, doneCycle: TO, modelResult: 16'd3,  expData: 16'd3,  expErr: 1'b0};
      vecs[7] = '{a: 16'd7,   b: 16'd7,  doneCycle: 1,  modelResult: 16'd7,  expData: 16'd7,  expErr: 1'b0};

      {if1.op_valid, if1.op_a, if1.op_b, if1.gcd_done, if1.gcd_result, if1.res_ready} = '0;
      {if3.op_valid, if3.op_a, if3.op_b, if3.gcd_done, if3.gcd_result, if3.res_ready} = '0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;

      checkOutput("rst_op_ready", 32'(if1.op_ready), 32'd1);
      checkOutput("rst_start", 32'(if1.gcd_start), 32'd0);
      checkOutput("rst_data", 32'(if1.gcd_data), 32'd0);
      checkOutput("rst_res_valid", 32'(if1.res_valid), 32'd0);
      checkOutput("rst_res_data", 32'(if1.res_data), 32'd0);
      checkOutput("rst_res_err", 32'(if1.res_err), 32'd0);
      checkOutput("rst_busy", 32'(if1.busy), 32'd0);
      checkOutput("rst3_busy", 32'(if3.busy), 32'd0);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i]);
         completeResp();
      end

      // Backpressure: result 7 held while downstream stalls and upstream pushes
      v = '{a: 16'd21, b: 16'd14, doneCycle: 3, modelResult: 16'd7, expData: 16'd7, expErr: 1'b0};
      applyStimulus(v);
      if1.op_valid = 1'b1;
      if1.op_a     = 16'd0;
      if1.op_b     = 16'd5;
      for (int i = 0; i < 10; i++) begin
         step();
         checkOutput("bp_res_valid", 32'(if1.res_valid), 32'd1);
         checkOutput("bp_res_data", 32'(if1.res_data), 32'd7);
         checkOutput("bp_op_ready", 32'(if1.op_ready), 32'd0);
      end
      if1.res_ready = 1'b1;
      step();
      if1.res_ready = 1'b0;
      checkOutput("bp_release_valid", 32'(if1.res_valid), 32'd0);
      checkOutput("bp_release_op_ready", 32'(if1.op_ready), 32'd1);
      step();
      if1.op_valid = 1'b0;
      checkOutput("bp_next_valid", 32'(if1.res_valid), 32'd1);
      checkOutput("bp_next_data", 32'(if1.res_data), 32'd5);
      checkOutput("bp_next_err", 32'(if1.res_err), 32'd0);
      completeResp();

      // Reset in the middle of WAIT, then a stray done
      if1.op_a     = 16'd30;
      if1.op_b     = 16'd12;
      if1.op_valid = 1'b1;
      step();
      if1.op_valid = 1'b0;
      for (int i = 0; i < 5; i++) step();
      checkOutput("pre_rst_start", 32'(if1.gcd_start), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkOutput("mid_rst_start", 32'(if1.gcd_start), 32'd0);
      checkOutput("mid_rst_data", 32'(if1.gcd_data), 32'd0);
      checkOutput("mid_rst_res_valid", 32'(if1.res_valid), 32'd0);
      checkOutput("mid_rst_res_data", 32'(if1.res_data), 32'd0);
      checkOutput("mid_rst_busy", 32'(if1.busy), 32'd0);
      checkOutput("mid_rst_op_ready", 32'(if1.op_ready), 32'd1);
      if1.gcd_done   = 1'b1;
      if1.gcd_result = 16'd6;
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput("late_done_res_valid", 32'(if1.res_valid), 32'd0);
         checkOutput("late_done_busy", 32'(if1.busy), 32'd0);
      end
      if1.gcd_done   = 1'b0;
      if1.gcd_result = '0;

      // LOAD_CYC=3 instance with a spurious done during LOAD_A
      if3.op_a     = 16'd48;
      if3.op_b     = 16'd18;
      if3.op_valid = 1'b1;
      step();
      if3.op_valid = 1'b0;
      for (int i = 0; i < LC3; i++) begin
         checkOutput("lc3_load_a_data", 32'(if3.gcd_data), 32'd48);
         checkOutput("lc3_load_a_start", 32'(if3.gcd_start), 32'd1);
         if (i == 1) begin
            if3.gcd_done   = 1'b1;
            if3.gcd_result = 16'd99;
         end
         step();
         if3.gcd_done   = 1'b0;
         if3.gcd_result = '0;
      end
      for (int i = 0; i < LC3; i++) begin
         checkOutput("lc3_load_b_data", 32'(if3.gcd_data), 32'd18);
         checkOutput("lc3_load_b_valid", 32'(if3.res_valid), 32'd0);
         step();
      end
      for (int w = 1; w <= 4; w++) begin
         checkOutput("lc3_wait_data", 32'(if3.gcd_data), 32'd18);
         checkOutput("lc3_wait_valid", 32'(if3.res_valid), 32'd0);
         if (w == 4) begin
            if3.gcd_done   = 1'b1;
            if3.gcd_result = 16'd6;
         end
         step();
         if3.gcd_done   = 1'b0;
         if3.gcd_result = '0;
      end
      checkOutput("lc3_res_valid", 32'(if3.res_valid), 32'd1);
      checkOutput("lc3_res_data", 32'(if3.res_data), 32'd6);
      checkOutput("lc3_res_err", 32'(if3.res_err), 32'd0);
      checkOutput("lc3_start_drop", 32'(if3.gcd_start), 32'd0);
      if3.res_ready = 1'b1;
      step();
      if3.res_ready = 1'b0;
      checkOutput("lc3_idle_valid", 32'(if3.res_valid), 32'd0);
      checkOutput("lc3_idle_busy", 32'(if3.busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", numApplied, numMiscompares);
      $finish;
   end

endmodule

// File: doc/gcd_operand_sequencer.md
Name: gcd_operand_sequencer

Overview:
- Initiator-side driver for the subtractive GCD datapath/controller pair.
- Accepts an operand pair (A, B) from upstream over a valid/ready handshake.
- Serialises the pair onto the 16-bit shared data_in bus (A first, then B) while asserting start, waits for done, then captures the GCD result.
- Returns the result downstream over a valid/ready handshake. Handles zero operands locally and enforces a completion timeout.

Parameters:
- WIDTH, 16, operand/result width; matches the GCD bus width.
- LOAD_CYC, 1, cycles each operand is held on gcd_data (1..15).
- TIMEOUT, 65535, max cycles in WAIT before declaring timeout (1..65535).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- op_valid  input  1  upstream operand pair valid
- op_ready  output  1  sequencer can accept a pair
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B
- gcd_start  output  1  start level to GCD controller
- gcd_data  output  WIDTH  drives GCD data_in
- gcd_done  input  1  done from GCD controller
- gcd_result  input  WIDTH  GCD A-register value, valid while gcd_done=1
- res_valid  output  1  result valid
- res_ready  input  1  downstream accepts result
- res_data  output  WIDTH  GCD result
- res_err  output  1  1 = both operands zero or timeout; qualified by res_valid
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE. op_ready=1, gcd_start=0, gcd_data=0, res_valid=0, res_data=0, res_err=0, busy=0, counters cleared. Reset mid-operation aborts immediately; any pending result is discarded.
- States: IDLE, LOAD_A, LOAD_B, WAIT, RESP.
- All outputs are registered except op_ready, which is (state==IDLE).
- IDLE: on op_valid&op_ready, latch op_a/op_b.
  - Both zero -> RESP with res_data=0, res_err=1; no GCD start.
  - Exactly one zero -> RESP with res_data=nonzero operand, res_err=0; no GCD start.
  - Otherwise -> LOAD_A with gcd_start=1, gcd_data=A, cycle counter=0.
- LOAD_A: gcd_start=1, gcd_data=A for exactly LOAD_CYC cycles, then LOAD_B.
- LOAD_B: gcd_start=1, gcd_data=B for exactly LOAD_CYC cycles, then WAIT.
- WAIT:
  - gcd_start=1 and gcd_data=B are held.
  - The timeout counter increments each cycle.
  - gcd_done sampled high -> capture gcd_result into res_data, res_err=0, go to RESP, drop gcd_start.
  - Counter reaches TIMEOUT with gcd_done low -> res_data=0, res_err=1, go to RESP.
  - gcd_done high in the same cycle the counter hits TIMEOUT -> done wins (res_err=0).
- gcd_done observed in IDLE/LOAD_A/LOAD_B is ignored.
- RESP: res_valid=1 and res_data/res_err held stable until res_valid&res_ready. The handshake cycle returns to IDLE, and res_valid drops the next cycle.
- gcd_data returns to 0 and gcd_start to 0 in RESP and IDLE.
- No overlap: op_ready=0 from LOAD_A through RESP, so a new pair is accepted only in IDLE. Back-to-back throughput is therefore one pair per full round trip.
- Latency, nonzero operands: op accept edge -> first LOAD_A cycle is next cycle. gcd_start is high for 2*LOAD_CYC cycles plus the WAIT duration. res_valid rises one cycle after gcd_done is sampled.
- Latency, zero-operand path: res_valid rises one cycle after accept.
- Widths: all data WIDTH bits unsigned. The timeout counter is 16 bits and saturates, never wraps.

Test Plan:
- Basic: op_a=143, op_b=78, GCD model returns done with result 13 after 20 cycles -> gcd_data=143 for 1 cycle, then 78 held; res_data=13, res_err=0, res_valid one cycle after done.
- Zero operands: (0,0) -> res_data=0, res_err=1, gcd_start never asserts. (0,25) -> res_data=25, res_err=0. (40,0) -> res_data=40, res_err=0.
- Timeout: TIMEOUT=50, model never asserts done -> res_err=1, res_data=0 exactly 50 WAIT cycles after entering WAIT; gcd_start drops on entering RESP.
- Backpressure: res_ready=0 for 10 cycles after result 7 -> res_valid and res_data=7 stable throughout, op_ready=0, new op_valid not accepted. Release -> IDLE next cycle, next pair accepted.
- Reset mid-WAIT: assert rst during WAIT -> next edge all outputs at reset values; a late gcd_done is ignored and produces no res_valid.
- LOAD_CYC=3, operands (48,18) -> gcd_data=48 for 3 cycles then 18; result 6 returned with res_err=0; done pulse during LOAD_A is injected and ignored.
